// File: rtl/mult_pipeline.sv
// mult_pipeline: RV32M MUL/MULH/MULHSU/MULHU datapath, STAGES registers deep,
// carrying rd, pc and instruction alongside each result to writeback.
// Optional feature macro: MULT_EARLY_LO_EN (MUL results leave after 2 edges).
module mult_pipeline #(
    parameter int STAGES = 5
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        kill_i,
    input  logic [31:0] mult1_src1_i,
    input  logic [31:0] mult1_src2_i,
    input  logic [4:0]  mult1_write_addr_i,
    input  logic        mult1_int_write_enable_i,
    input  logic [31:0] mult1_instruction_i,
    input  logic [31:0] mult1_pc_i,
    input  logic [4:0]  hazard_rs1_i,
    input  logic [4:0]  hazard_rs2_i,
    output logic [31:0] wb_int_write_data_o,
    output logic [4:0]  wb_write_addr_o,
    output logic        wb_int_write_enable_o,
    output logic [31:0] wb_instruction_o,
    output logic [31:0] wb_pc_o,
    output logic        hazard_o,
    output logic        busy_o
);

    localparam int LAST = STAGES - 1;
    // Stage whose op would reach the output together with an early MUL issued now.
    localparam int COLL = (STAGES >= 3) ? STAGES - 3 : 0;

`ifdef MULT_EARLY_LO_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] we_q;
    logic [1:0]        early_q;
    logic [4:0]        rd_q    [STAGES];
    logic [31:0]       instr_q [STAGES];
    logic [31:0]       pc_q    [STAGES];
    logic [63:0]       prod_q  [STAGES];

    logic        is_mult;
    logic [1:0]  funct;
    logic        a_sign;
    logic        b_sign;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    logic        o_valid;
    logic        o_we;
    logic [4:0]  o_rd;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [63:0] o_prod;
    logic        coll_early;

    // Decode the incoming op and form the 64-bit product of the 33-bit operands.
    always_comb begin
        is_mult = (mult1_instruction_i[31:25] == 7'b0000001) &&
                  (mult1_instruction_i[6:0] == 7'b0110011) &&
                  !mult1_instruction_i[14];
        funct   = mult1_instruction_i[13:12];
        a_sign  = (funct != 2'b11) & mult1_src1_i[31];
        b_sign  = (funct[1] == 1'b0) & mult1_src2_i[31];
        a_ext   = {{32{a_sign}}, mult1_src1_i};
        b_ext   = {{32{b_sign}}, mult1_src2_i};
        product = a_ext * b_ext;
    end

    // Load stage 1, shift the rest; kill and reset flush every stage.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i || kill_i) begin
            valid_q <= '0;
            we_q    <= '0;
            early_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                rd_q[i]    <= '0;
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                prod_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= is_mult;
            we_q[0]    <= is_mult & mult1_int_write_enable_i;
            rd_q[0]    <= mult1_write_addr_i;
            instr_q[0] <= mult1_instruction_i;
            pc_q[0]    <= mult1_pc_i;
            prod_q[0]  <= is_mult ? product : 64'd0;
            early_q[0] <= EARLY_EN & is_mult & (funct == 2'b00);
            early_q[1] <= early_q[0];
            for (int i = 1; i < STAGES; i++) begin
                if (EARLY_EN && i == 2 && early_q[1]) begin
                    valid_q[i] <= 1'b0;
                    we_q[i]    <= 1'b0;
                    rd_q[i]    <= '0;
                    instr_q[i] <= '0;
                    pc_q[i]    <= '0;
                    prod_q[i]  <= '0;
                end else begin
                    valid_q[i] <= valid_q[i-1];
                    we_q[i]    <= we_q[i-1];
                    rd_q[i]    <= rd_q[i-1];
                    instr_q[i] <= instr_q[i-1];
                    pc_q[i]    <= pc_q[i-1];
                    prod_q[i]  <= prod_q[i-1];
                end
            end
        end
    end

    // Pick the exiting stage (early MUL from stage 2 if enabled) and select the result half.
    always_comb begin
        o_valid = valid_q[LAST];
        o_we    = we_q[LAST];
        o_rd    = rd_q[LAST];
        o_instr = instr_q[LAST];
        o_pc    = pc_q[LAST];
        o_prod  = prod_q[LAST];
        if (EARLY_EN && early_q[1]) begin
            o_valid = valid_q[1];
            o_we    = we_q[1];
            o_rd    = rd_q[1];
            o_instr = instr_q[1];
            o_pc    = pc_q[1];
            o_prod  = prod_q[1];
        end
        wb_int_write_data_o   = (o_instr[13:12] == 2'b00) ? o_prod[31:0] : o_prod[63:32];
        wb_write_addr_o       = o_rd;
        wb_int_write_enable_o = o_valid & o_we & (o_rd != 5'd0);
        wb_instruction_o      = o_instr;
        wb_pc_o               = o_pc;
    end

    // Flag RAW hazards against pending rds; the final stage is forwarded by writeback.
    always_comb begin
        coll_early = (COLL == 0) ? early_q[0] : ((COLL == 1) ? early_q[1] : 1'b0);
        hazard_o   = 1'b0;
        for (int i = 0; i < LAST; i++) begin
            if (valid_q[i] && we_q[i] && (rd_q[i] != 5'd0) &&
                ((rd_q[i] == hazard_rs1_i) || (rd_q[i] == hazard_rs2_i))) begin
                hazard_o = 1'b1;
            end
        end
        if (EARLY_EN && (STAGES >= 3) && valid_q[COLL] && !coll_early) begin
            hazard_o = 1'b1;
        end
    end

    assign busy_o = |valid_q;

endmodule

// File: tb/tb_mult_pipeline.sv
// tb_mult_pipeline: directed vector table plus hand-written multi-cycle
// sequences (back-to-back issue, kill flush, asynchronous reset).
module tb_mult_pipeline;

    localparam int STAGES = 5;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  rd_in = '0;
    logic        we_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [31:0] wb_instr;
    logic [31:0] wb_pc;
    logic        hazard;
    logic        busy;

    int num_applied = 0;
    int num_miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        chk_data;
    } vec_t;

    vec_t vecs[13];

    mult_pipeline #(.STAGES(STAGES)) dut (
        .clk_i                    (clk),
        .rsn_i                    (rsn),
        .kill_i                   (kill),
        .mult1_src1_i             (src1),
        .mult1_src2_i             (src2),
        .mult1_write_addr_i       (rd_in),
        .mult1_int_write_enable_i (we_in),
        .mult1_instruction_i      (instr_in),
        .mult1_pc_i               (pc_in),
        .hazard_rs1_i             (rs1),
        .hazard_rs2_i             (rs2),
        .wb_int_write_data_o      (wb_data),
        .wb_write_addr_o          (wb_addr),
        .wb_int_write_enable_o    (wb_we),
        .wb_instruction_o         (wb_instr),
        .wb_pc_o                  (wb_pc),
        .hazard_o                 (hazard),
        .busy_o                   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_applied++;
        if (act !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] ins,
                                  input logic [31:0] pc, input logic [4:0] rd, input logic we);
        src1     = s1;
        src2     = s2;
        instr_in = ins;
        pc_in    = pc;
        rd_in    = rd;
        we_in    = we;
    endtask

    task automatic drive_idle();
        apply_stimulus(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic check_wb_zero(input string tag);
        check_output({tag, ".data"}, wb_data, 32'd0);
        check_output({tag, ".addr"}, {27'd0, wb_addr}, 32'd0);
        check_output({tag, ".we"}, {31'd0, wb_we}, 32'd0);
        check_output({tag, ".instr"}, wb_instr, 32'd0);
        check_output({tag, ".pc"}, wb_pc, 32'd0);
        check_output({tag, ".hazard"}, {31'd0, hazard}, 32'd0);
        check_output({tag, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{mk_r(7'h01, 3'b000, 5'd5),  32'hFFFFFFFF, 32'd7,        32'h100, 5'd5,  1'b1, 32'hFFFFFFF9, 1'b1, 1'b1};
        vecs[1]  = '{mk_r(7'h01, 3'b001, 5'd6),  32'hFFFFFFFE, 32'd3,        32'h104, 5'd6,  1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[2]  = '{mk_r(7'h01, 3'b011, 5'd7),  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h108, 5'd7,  1'b1, 32'hFFFFFFFE, 1'b1, 1'b1};
        vecs[3]  = '{mk_r(7'h01, 3'b010, 5'd8),  32'hFFFFFFFF, 32'd2,        32'h10C, 5'd8,  1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[4]  = '{mk_r(7'h01, 3'b000, 5'd9),  32'h12345678, 32'h10,       32'h110, 5'd9,  1'b1, 32'h23456780, 1'b1, 1'b1};
        vecs[5]  = '{mk_r(7'h01, 3'b001, 5'd10), 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h114, 5'd10, 1'b1, 32'h3FFFFFFF, 1'b1, 1'b1};
        vecs[6]  = '{mk_r(7'h01, 3'b011, 5'd11), 32'h80000000, 32'd2,        32'h118, 5'd11, 1'b1, 32'h00000001, 1'b1, 1'b1};
        vecs[7]  = '{mk_r(7'h01, 3'b010, 5'd12), 32'h80000000, 32'hFFFFFFFF, 32'h11C, 5'd12, 1'b1, 32'h80000000, 1'b1, 1'b1};
        vecs[8]  = '{mk_r(7'h01, 3'b001, 5'd13), 32'h80000000, 32'h80000000, 32'h120, 5'd13, 1'b1, 32'h40000000, 1'b1, 1'b1};
        vecs[9]  = '{mk_r(7'h01, 3'b000, 5'd0),  32'd3,        32'd4,        32'h124, 5'd0,  1'b1, 32'd0,        1'b0, 1'b0};
        vecs[10] = '{mk_r(7'h01, 3'b000, 5'd14), 32'd3,        32'd5,        32'h128, 5'd14, 1'b0, 32'd15,       1'b0, 1'b1};
        vecs[11] = '{mk_r(7'h01, 3'b100, 5'd15), 32'd100,      32'd5,        32'h12C, 5'd15, 1'b1, 32'd0,        1'b0, 1'b1};
        vecs[12] = '{mk_r(7'h00, 3'b000, 5'd16), 32'd100,      32'd5,        32'h130, 5'd16, 1'b1, 32'd0,        1'b0, 1'b1};

        // Reset state while rsn is held low.
        repeat (2) @(negedge clk);
        check_wb_zero("reset");
        rsn = 1'b1;

        // Table-driven vectors, one op in flight at a time.
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            apply_stimulus(vecs[v].src1, vecs[v].src2, vecs[v].instr, vecs[v].pc, vecs[v].rd, vecs[v].we);
            @(negedge clk);
            drive_idle();
            repeat (STAGES - 1) @(negedge clk);
            if (vecs[v].chk_data)
                check_output($sformatf("vec%0d.data", v), wb_data, vecs[v].exp_data);
            check_output($sformatf("vec%0d.addr", v), {27'd0, wb_addr}, {27'd0, vecs[v].rd});
            check_output($sformatf("vec%0d.we", v), {31'd0, wb_we}, {31'd0, vecs[v].exp_we});
            check_output($sformatf("vec%0d.instr", v), wb_instr, vecs[v].instr);
            check_output($sformatf("vec%0d.pc", v), wb_pc, vecs[v].pc);
        end

        // Back-to-back MULs rd=1..4 with hazard probe on rs1=3.
        rs1 = 5'd3;
        for (int j = 1; j <= 9; j++) begin
            if (j <= 4)
                apply_stimulus(32'(j), 32'd10, mk_r(7'h01, 3'b000, 5'(j)), 32'h200 + 32'(4 * j), 5'(j), 1'b1);
            else
                drive_idle();
            @(negedge clk);
            check_output($sformatf("b2b%0d.hazard", j), {31'd0, hazard}, {31'd0, (j >= 3 && j <= 6)});
            check_output($sformatf("b2b%0d.busy", j), {31'd0, busy}, {31'd0, (j <= 8)});
            check_output($sformatf("b2b%0d.we", j), {31'd0, wb_we}, {31'd0, (j >= 5 && j <= 8)});
            if (j >= 5 && j <= 8) begin
                check_output($sformatf("b2b%0d.data", j), wb_data, 32'(10 * (j - 4)));
                check_output($sformatf("b2b%0d.addr", j), {27'd0, wb_addr}, 32'(j - 4));
                check_output($sformatf("b2b%0d.pc", j), wb_pc, 32'h200 + 32'(4 * (j - 4)));
            end
        end

        // Kill with three ops in flight and a fourth at the input.
        rs1 = 5'd2;
        for (int j = 1; j <= 3; j++) begin
            apply_stimulus(32'd7, 32'd9, mk_r(7'h01, 3'b000, 5'(j)), 32'h300 + 32'(4 * j), 5'(j), 1'b1);
            @(negedge clk);
        end
        apply_stimulus(32'd7, 32'd9, mk_r(7'h01, 3'b000, 5'd4), 32'h310, 5'd4, 1'b1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        drive_idle();
        check_wb_zero("kill");
        for (int j = 0; j < STAGES + 1; j++) begin
            @(negedge clk);
            check_output($sformatf("postkill%0d.we", j), {31'd0, wb_we}, 32'd0);
        end

        // Asynchronous reset with the first op already at the output.
        rs1 = 5'd1;
        for (int j = 1; j <= STAGES; j++) begin
            apply_stimulus(32'd2, 32'd3, mk_r(7'h01, 3'b000, 5'(j)), 32'h400 + 32'(4 * j), 5'(j), 1'b1);
            @(negedge clk);
        end
        drive_idle();
        check_output("prerst.we", {31'd0, wb_we}, 32'd1);
        check_output("prerst.data", wb_data, 32'd6);
        #2 rsn = 1'b0;
        #1 check_wb_zero("asyncrst");
        @(negedge clk);
        rsn = 1'b1;
        for (int j = 0; j < STAGES + 1; j++) begin
            @(negedge clk);
            check_output($sformatf("postrst%0d.we", j), {31'd0, wb_we}, 32'd0);
            check_output($sformatf("postrst%0d.busy", j), {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_applied, num_miscompares);
        $finish;
    end

endmodule
